// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable framing, a
// valid/ready output holding register, and sticky overrun reporting.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int BAUD_DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int BAUD_DIV     = (BAUD_DIV_RAW < 1) ? 1 : BAUD_DIV_RAW;
    localparam int DIV_W        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int OS_W         = $clog2(OVERSAMPLE);
    localparam int HALF         = OVERSAMPLE / 2;
    localparam logic ODD_PAR    = (PARITY == 2);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PAR, STOP, WAIT_IDLE
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
    logic [DIV_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [OS_W-1:0]      smp_cnt_q, smp_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 first_stop_q, first_stop_d;
    logic                 fe_acc_q, fe_acc_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic                 bd_q, bd_d;
    logic                 ovr_q, ovr_d;

    logic rx_s, tick, full_pt, done, accept;
    logic new_pe, new_fe, new_bd, cur_first_stop;

    assign rx_s    = rx_s2_q;
    assign tick    = (baud_cnt_q == DIV_W'(BAUD_DIV - 1));
    assign full_pt = (smp_cnt_q == OS_W'(OVERSAMPLE - 1));
    assign accept  = dv_q && data_ready;

    // Synchronizer and free-running oversample tick generator.
    always_comb begin
        rx_s1_d    = rx_in;
        rx_s2_d    = rx_s1_q;
        baud_cnt_d = tick ? '0 : baud_cnt_q + 1'b1;
    end

    // Frame FSM: advances only on ticks, samples mid-bit.
    always_comb begin
        state_d      = state_q;
        smp_cnt_d    = smp_cnt_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        first_stop_d = first_stop_q;
        fe_acc_d     = fe_acc_q;
        done         = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d   = START;
                        smp_cnt_d = '0;
                    end
                end
                START: begin
                    if (smp_cnt_q == OS_W'(HALF - 1)) begin
                        smp_cnt_d = '0;
                        bit_idx_d = '0;
                        state_d   = rx_s ? IDLE : DATA;
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (full_pt) begin
                        smp_cnt_d = '0;
                        shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                            state_d    = (PARITY != 0) ? PAR : STOP;
                            stop_idx_d = 1'b0;
                            fe_acc_d   = 1'b0;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
                PAR: begin
                    if (full_pt) begin
                        smp_cnt_d = '0;
                        par_bit_d = rx_s;
                        state_d   = STOP;
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (full_pt) begin
                        smp_cnt_d = '0;
                        fe_acc_d  = fe_acc_q | ~rx_s;
                        if (!stop_idx_q) first_stop_d = rx_s;
                        if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                            done    = 1'b1;
                            state_d = rx_s ? IDLE : WAIT_IDLE;
                        end else begin
                            stop_idx_d = 1'b1;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Frame status as seen on the final stop-sample tick (includes that sample).
    always_comb begin
        cur_first_stop = stop_idx_q ? first_stop_q : rx_s;
        new_fe         = fe_acc_q | ~rx_s;
        new_pe         = (PARITY != 0) && ((^shift_q ^ par_bit_q) != ODD_PAR);
        new_bd         = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && !cur_first_stop;
    end

    // Output holding register: load on completion if free or being accepted,
    // otherwise drop the new frame and flag overrun.
    always_comb begin
        data_d = data_q;
        dv_d   = dv_q;
        pe_d   = pe_q;
        fe_d   = fe_q;
        bd_d   = bd_q;
        ovr_d  = ovr_q;
        if (done && (!dv_q || accept)) begin
            data_d = shift_q;
            pe_d   = new_pe;
            fe_d   = new_fe;
            bd_d   = new_bd;
            dv_d   = 1'b1;
        end else if (done) begin
            ovr_d = 1'b1;
        end else if (accept) begin
            dv_d = 1'b0;
        end
        if (accept) ovr_d = 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            baud_cnt_q   <= '0;
            smp_cnt_q    <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            first_stop_q <= 1'b1;
            fe_acc_q     <= 1'b0;
            data_q       <= '0;
            dv_q         <= 1'b0;
            pe_q         <= 1'b0;
            fe_q         <= 1'b0;
            bd_q         <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_s1_q      <= rx_s1_d;
            rx_s2_q      <= rx_s2_d;
            baud_cnt_q   <= baud_cnt_d;
            smp_cnt_q    <= smp_cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            first_stop_q <= first_stop_d;
            fe_acc_q     <= fe_acc_d;
            data_q       <= data_d;
            dv_q         <= dv_d;
            pe_q         <= pe_d;
            fe_q         <= fe_d;
            bd_q         <= bd_d;
            ovr_q        <= ovr_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = dv_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign break_det  = bd_q;
    assign overrun    = ovr_q;

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLK_FREQ, default 25_000_000: clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600: line bit rate in bit/s.
REQ-003 Parameter OVERSAMPLE, default 16: ticks per bit; even value, 8..16.
REQ-004 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..8.
REQ-005 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-006 Parameter STOP_BITS, default 1: 1 or 2.
REQ-007 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 Port rx_in, input, 1 bit: asynchronous serial line; idle high.
REQ-010 Port data_out, output, DATA_BITS bits: received word, LSB = first bit received.
REQ-011 Port data_valid, output, 1 bit: data_out and the flags are valid; held until accepted.
REQ-012 Port data_ready, input, 1 bit: consumer accepts the word when data_valid && data_ready.
REQ-013 Port parity_err, output, 1 bit: parity mismatch for the presented word; always 0 when PARITY = 0.
REQ-014 Port frame_err, output, 1 bit: one or more stop bits sampled as 0 for the presented word.
REQ-015 Port break_det, output, 1 bit: presented word is all zeros, parity (if any) is 0, and first stop bit is 0.
REQ-016 Port overrun, output, 1 bit: sticky flag; a completed frame was dropped.

Function
REQ-017 rx_in SHALL pass through a 2-flop synchronizer (reset value 1); all sampling uses the synchronized value.
REQ-018 BAUD_DIV SHALL equal CLK_FREQ/(BAUD_RATE*OVERSAMPLE), truncated, with a minimum of 1; the free-running tick SHALL be high for 1 cycle in every BAUD_DIV cycles.
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; the FSM advances only on tick cycles.
REQ-020 IDLE: a tick with synced rx = 0 SHALL enter START and clear the sample counter.
REQ-021 START: on the (OVERSAMPLE/2)-th tick, sample; 1 -> IDLE (false start, no output); 0 -> DATA, counter cleared, bit index 0.
REQ-022 DATA/PARITY/STOP: each bit SHALL be sampled on every OVERSAMPLE-th tick after the previous sample; data is shifted LSB-first.
REQ-023 After DATA_BITS data samples: go to PARITY if PARITY != 0, else STOP; after the parity sample go to STOP.
REQ-024 Parity check: for even parity, the XOR of the data bits and the parity bit SHALL be 0; for odd parity, it SHALL be 1.
REQ-025 STOP samples STOP_BITS bits; frame_err is the OR of all stop bits sampled as 0; no early abort.
REQ-026 After the final stop sample: IDLE if the last stop sample = 1; otherwise WAIT_IDLE, which returns to IDLE on the first tick with synced rx = 1.
REQ-027 Completion: in the cycle after the final stop-sample tick, data_out, parity_err, frame_err and break_det SHALL load, and data_valid SHALL assert.
REQ-028 data_valid and the flags SHALL hold unchanged until the cycle after data_valid && data_ready; data_valid then deasserts, unless REQ-029 applies.
REQ-029 If a completion coincides with an accepting cycle (data_valid && data_ready), the new word SHALL load, data_valid SHALL stay 1, and overrun SHALL be unaffected.
REQ-030 If a frame completes while data_valid && !data_ready: the new frame SHALL be discarded, the held word kept, and overrun set.
REQ-031 overrun SHALL clear in the cycle after the next data_valid && data_ready.
REQ-032 Reception SHALL continue independently of data_ready; no backpressure reaches the line.

Reset
REQ-033 On reset: state = IDLE, counters = 0, synchronizer = 1, data_out = 0, and data_valid, parity_err, frame_err, break_det, overrun = 0.
REQ-034 Reset mid-frame SHALL abandon the frame with no output; reception resumes on the next falling edge after reset deasserts.

Verification
Bench parameters: CLK_FREQ = 1_600_000, BAUD_RATE = 100_000, OVERSAMPLE = 16 (BAUD_DIV = 1, 16 clk/bit), data_ready = 1 unless stated.
REQ-035 8N1 frame carrying 0xA5 -> data_out = 0xA5, data_valid high for exactly 1 cycle, all flags 0.
REQ-036 PARITY = 1, frame 0x03 with parity bit 1 -> data_out = 0x03, parity_err = 1; the same frame with parity bit 0 -> parity_err = 0.
REQ-037 8N1 frame 0x00 with stop held 0 for 3 bit times -> frame_err = 1, break_det = 1; no second word until the line returns high and a new start bit arrives.
REQ-038 Low glitch of 4 clk on idle line -> no data_valid, FSM back in IDLE.
REQ-039 data_ready = 0, two frames 0x11 then 0x22 -> data_out stays 0x11 and overrun = 1; raise data_ready -> one accept, then overrun = 0 and data_valid = 0.
REQ-040 Assert reset for 1 cycle at data bit 4 of frame 0x5A, then send 0x3C -> the only word output is 0x3C, flags 0.
